// File: rtl/game_sequencer.sv
// Purpose    : run/pause/game-over sequencer for the runner game; owns the scroll-tick divider,
//              score-driven speed-up, button edge detection, jump latching, score and high score.
// Latency    : button inputs act 3 clk after they rise (2-FF sync + edge flop); all outputs registered.
// Backpressure: none; the datapath consumes step/jump as single-cycle pulses.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   go, stop, jump_btn  asynchronous level buttons (start/restart, pause/resume, jump)
//   lose                collision flag from the datapath, synchronous to clk
//   init, move          datapath reinitialise / advance-enable
//   step, jump          one-cycle scroll-tick pulse and coincident jump request
//   state, cd_left      FSM state (0 IDLE,1 COUNTDOWN,2 RUN,3 PAUSE,4 OVER), countdown ticks left
//   score, high_score   ticks survived this game (saturating), best since reset
//   rate_now            current tick period in clk cycles
module game_sequencer #(
    parameter logic [27:0] BASE_RATE       = 28'd3000000,
    parameter logic [27:0] MIN_RATE        = 28'd750000,
    parameter logic [27:0] RATE_STEP       = 28'd250000,
    parameter logic [15:0] LEVEL_SCORE     = 16'd32,
    parameter logic [1:0]  COUNTDOWN_TICKS = 2'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic        stop,
    input  logic        jump_btn,
    input  logic        lose,
    output logic        init,
    output logic        move,
    output logic        step,
    output logic        jump,
    output logic [2:0]  state,
    output logic [1:0]  cd_left,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic [27:0] rate_now
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_RUN       = 3'd2,
        S_PAUSE     = 3'd3,
        S_OVER      = 3'd4
    } state_t;

    state_t      state_q;
    logic [27:0] div_cnt;
    logic        jump_latch;

    // Button synchronisers: bit 0 go, bit 1 stop, bit 2 jump_btn.
    logic [2:0] sync1, sync2, sync_d;
    logic [2:0] btn_edge;
    logic       go_edge, stop_edge, jump_edge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= 3'b000;
            sync2  <= 3'b000;
            sync_d <= 3'b000;
        end else begin
            sync1  <= {jump_btn, stop, go};
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign btn_edge  = sync2 & ~sync_d;
    assign go_edge   = btn_edge[0];
    assign stop_edge = btn_edge[1];
    assign jump_edge = btn_edge[2];

    // Tick fires on the cycle the divider sits at zero; the reload on that
    // same edge uses the rate in force before any speed-up from this tick.
    logic        tick;
    logic [15:0] score_inc;
    logic        level_up;
    logic [27:0] rate_dec;
    logic [15:0] high_next;

    assign tick      = (div_cnt == 28'd0);
    assign score_inc = (score == 16'hFFFF) ? score : score + 16'd1;
    assign level_up  = ((score_inc & (LEVEL_SCORE - 16'd1)) == 16'd0);
    assign rate_dec  = (rate_now >= MIN_RATE + RATE_STEP) ? rate_now - RATE_STEP : MIN_RATE;
    assign high_next = (score > high_score) ? score : high_score;

    assign state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            init       <= 1'b1;
            move       <= 1'b0;
            step       <= 1'b0;
            jump       <= 1'b0;
            cd_left    <= 2'd0;
            score      <= 16'd0;
            high_score <= 16'd0;
            rate_now   <= BASE_RATE;
            div_cnt    <= BASE_RATE - 28'd1;
            jump_latch <= 1'b0;
        end else begin
            step <= 1'b0;
            jump <= 1'b0;
            case (state_q)
                S_IDLE, S_OVER: begin
                    move    <= 1'b0;
                    div_cnt <= rate_now - 28'd1;
                    if (go_edge) begin
                        state_q    <= S_COUNTDOWN;
                        init       <= 1'b1;
                        cd_left    <= COUNTDOWN_TICKS;
                        score      <= 16'd0;
                        rate_now   <= BASE_RATE;
                        // The held reload value may still reflect the last game's speed.
                        div_cnt    <= BASE_RATE - 28'd1;
                        jump_latch <= 1'b0;
                    end else begin
                        init <= (state_q == S_IDLE);
                    end
                end

                S_COUNTDOWN: begin
                    init       <= 1'b1;
                    move       <= 1'b0;
                    jump_latch <= 1'b0;
                    if (tick) begin
                        div_cnt <= rate_now - 28'd1;
                        if (cd_left <= 2'd1) begin
                            state_q <= S_RUN;
                            cd_left <= 2'd0;
                            init    <= 1'b0;
                            move    <= 1'b1;
                        end else begin
                            cd_left <= cd_left - 2'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt - 28'd1;
                    end
                end

                S_RUN: begin
                    init    <= 1'b0;
                    move    <= 1'b1;
                    div_cnt <= tick ? rate_now - 28'd1 : div_cnt - 28'd1;
                    if (lose) begin
                        // Collision beats any step or pause request this cycle.
                        state_q    <= S_OVER;
                        move       <= 1'b0;
                        high_score <= high_next;
                    end else begin
                        if (tick) begin
                            step       <= 1'b1;
                            jump       <= jump_latch | jump_edge;
                            jump_latch <= 1'b0;
                            score      <= score_inc;
                            if (level_up) begin
                                rate_now <= rate_dec;
                            end
                        end else if (jump_edge) begin
                            jump_latch <= 1'b1;
                        end
                        if (stop_edge) begin
                            state_q <= S_PAUSE;
                            move    <= 1'b0;
                        end
                    end
                end

                S_PAUSE: begin
                    init <= 1'b0;
                    move <= 1'b0;
                    if (go_edge) begin
                        state_q    <= S_OVER;
                        high_score <= high_next;
                    end else if (stop_edge) begin
                        state_q <= S_RUN;
                        move    <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    init    <= 1'b1;
                    move    <= 1'b0;
                    cd_left <= 2'd0;
                    div_cnt <= rate_now - 28'd1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Purpose    : self-checking bench for game_sequencer with small rate parameters.
// Latency    : expected step results are queued ahead of time and matched as each step appears.
// Backpressure: none.
module tb_game_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        go, stop, jump_btn, lose;
    logic        init, move, step, jump;
    logic [2:0]  state;
    logic [1:0]  cd_left;
    logic [15:0] score, high_score;
    logic [27:0] rate_now;

    game_sequencer #(
        .BASE_RATE       (28'd8),
        .MIN_RATE        (28'd4),
        .RATE_STEP       (28'd2),
        .LEVEL_SCORE     (16'd4),
        .COUNTDOWN_TICKS (2'd3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .stop       (stop),
        .jump_btn   (jump_btn),
        .lose       (lose),
        .init       (init),
        .move       (move),
        .step       (step),
        .jump       (jump),
        .state      (state),
        .cd_left    (cd_left),
        .score      (score),
        .high_score (high_score),
        .rate_now   (rate_now)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard of expected step results.
    typedef struct {
        int score;
        int rate;
        bit jmp;
        int gap;
        bit gap_chk;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model of score and rate progression.
    int m_score, m_rate, m_gap_next;

    task automatic model_reset();
        m_score    = 0;
        m_rate     = 8;
        m_gap_next = 8;
    endtask

    task automatic push_step(input bit j, input int extra, input bit gc);
        exp_t e;
        m_score++;
        e.gap      = m_gap_next + extra;
        m_gap_next = m_rate;          // reload uses the rate before this step's speed-up
        if (m_score % 4 == 0) m_rate = (m_rate - 2 < 4) ? 4 : m_rate - 2;
        e.score   = m_score;
        e.rate    = m_rate;
        e.jmp     = j;
        e.gap_chk = gc;
        sb.push_back(e);
    endtask

    // Step monitor: pops one expectation per observed step.
    int   last_step = 0;
    exp_t got;
    initial forever begin
        @(negedge clk);
        if (!reset && step) begin
            if (sb.size() == 0) begin
                check_val("step_unexpected", 32'(step), 32'd0);
            end else begin
                got = sb.pop_front();
                check_val("step_score", 32'(score), 32'(got.score));
                check_val("step_rate", 32'(rate_now), 32'(got.rate));
                check_val("step_jump", 32'(jump), 32'(got.jmp));
                if (got.gap_chk) check_val("step_gap", 32'(cyc - last_step), 32'(got.gap));
            end
            last_step = cyc;
        end
        if (jump && !step) check_val("jump_without_step", 32'(jump), 32'd0);
    end

    task automatic clk_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_step(input string tag);
        for (int i = 0; i < 64; i++) begin
            clk_n(1);
            if (step) return;
        end
        check_val(tag, 32'(step), 32'd1);
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        for (int i = 0; i < 64; i++) begin
            clk_n(1);
            if (state == s) return;
        end
        check_val(tag, 32'(state), 32'(s));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_state"}, 32'(state), 32'd0);
        check_val({tag, "_init"}, 32'(init), 32'd1);
        check_val({tag, "_move"}, 32'(move), 32'd0);
        check_val({tag, "_step"}, 32'(step), 32'd0);
        check_val({tag, "_jump"}, 32'(jump), 32'd0);
        check_val({tag, "_cd"}, 32'(cd_left), 32'd0);
        check_val({tag, "_score"}, 32'(score), 32'd0);
        check_val({tag, "_high"}, 32'(high_score), 32'd0);
        check_val({tag, "_rate"}, 32'(rate_now), 32'd8);
    endtask

    initial begin
        int a, b;
        reset = 1'b1;
        go = 1'b0; stop = 1'b0; jump_btn = 1'b0; lose = 1'b0;
        clk_n(3);
        check_reset_outputs("rst");
        reset = 1'b0;
        clk_n(2);

        // Game 1: countdown timing
        go = 1'b1;
        clk_n(2);
        check_val("go_sync_delay_state", 32'(state), 32'd0);
        clk_n(1);
        check_val("cd_enter_state", 32'(state), 32'd1);
        check_val("cd_enter_left", 32'(cd_left), 32'd3);
        check_val("cd_enter_init", 32'(init), 32'd1);
        clk_n(7);
        check_val("cd_hold_3", 32'(cd_left), 32'd3);
        go = 1'b0;
        clk_n(1);
        check_val("cd_2", 32'(cd_left), 32'd2);
        clk_n(8);
        check_val("cd_1", 32'(cd_left), 32'd1);
        clk_n(7);
        check_val("cd_not_yet_run", 32'(state), 32'd1);
        clk_n(1);
        check_val("run_state", 32'(state), 32'd2);
        check_val("run_init", 32'(init), 32'd0);
        check_val("run_move", 32'(move), 32'd1);
        check_val("run_cd", 32'(cd_left), 32'd0);

        model_reset();
        for (int k = 1; k <= 5; k++) push_step(k == 3, 0, k > 1);
        wait_step("step1_timeout");
        wait_step("step2_timeout");
        // Jump pressed mid-period and held across two steps.
        clk_n(3);
        jump_btn = 1'b1;
        wait_step("step3_timeout");
        wait_step("step4_timeout");
        jump_btn = 1'b0;
        wait_step("step5_timeout");

        // Pause at score 5.
        stop = 1'b1;
        a = cyc;
        clk_n(3);
        check_val("pause_state", 32'(state), 32'd3);
        check_val("pause_move", 32'(move), 32'd0);
        clk_n(3);
        stop = 1'b0;
        clk_n(94);
        check_val("pause_hold_state", 32'(state), 32'd3);
        check_val("pause_hold_score", 32'(score), 32'd5);
        stop = 1'b1;
        b = cyc;
        clk_n(3);
        check_val("resume_state", 32'(state), 32'd2);
        check_val("resume_move", 32'(move), 32'd1);
        stop = 1'b0;
        push_step(1'b0, b - a, 1'b1);
        for (int k = 7; k <= 9; k++) push_step(1'b0, 0, 1'b1);
        for (int k = 6; k <= 9; k++) wait_step("step_g1_timeout");

        // Lose coinciding with the tick that would give score 10.
        clk_n(3);
        lose = 1'b1;
        clk_n(1);
        lose = 1'b0;
        check_val("lose_tick_state", 32'(state), 32'd4);
        check_val("lose_tick_score", 32'(score), 32'd9);
        check_val("lose_tick_high", 32'(high_score), 32'd9);
        check_val("over_move", 32'(move), 32'd0);
        check_val("over_init", 32'(init), 32'd0);
        clk_n(2);

        // Game 2: replay to 6, high score must stay 9.
        go = 1'b1;
        clk_n(3);
        go = 1'b0;
        check_val("g2_state", 32'(state), 32'd1);
        check_val("g2_cd", 32'(cd_left), 32'd3);
        check_val("g2_score", 32'(score), 32'd0);
        check_val("g2_rate", 32'(rate_now), 32'd8);
        wait_state(3'd2, "g2_run_timeout");
        model_reset();
        for (int k = 1; k <= 6; k++) push_step(1'b0, 0, k > 1);
        for (int k = 1; k <= 6; k++) wait_step("step_g2_timeout");
        lose = 1'b1;
        clk_n(1);
        lose = 1'b0;
        check_val("g2_over_state", 32'(state), 32'd4);
        check_val("g2_over_score", 32'(score), 32'd6);
        check_val("g2_over_high", 32'(high_score), 32'd9);
        clk_n(2);

        // Game 3: 12 ticks with speed-up, then reset between edges.
        go = 1'b1;
        clk_n(3);
        go = 1'b0;
        check_val("g3_state", 32'(state), 32'd1);
        wait_state(3'd2, "g3_run_timeout");
        model_reset();
        for (int k = 1; k <= 12; k++) push_step(1'b0, 0, k > 1);
        for (int k = 1; k <= 12; k++) wait_step("step_g3_timeout");
        check_val("g3_score", 32'(score), 32'd12);
        check_val("g3_rate", 32'(rate_now), 32'd4);
        clk_n(2);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        clk_n(2);
        reset = 1'b0;
        check_val("sb_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
